// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage
//
// Issues word-aligned reads to instruction memory, buffers up to two returned
// words in a small FIFO while decode is stalled, and presents one instruction
// per cycle to decode through a registered output. A redirect from decode
// flushes everything in flight and restarts fetch at the branch target. A read
// that is still outstanding when a redirect arrives is allowed to finish, and
// its data is then dropped.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   stall_i           decode holding; output register frozen
//   branch_flag_i     redirect request (ignored while stall_i=1)
//   branch_address_i  redirect target
//   mem_req_o         instruction memory read request
//   mem_addr_o        word-aligned fetch address
//   mem_ack_i         read complete; mem_rdata_i valid this cycle
//   mem_rdata_i       fetched instruction word
//   pc_o              PC of inst_o
//   inst_o            instruction to decode (NOP_INST when a bubble)
//   inst_valid_o      inst_o is a real fetched instruction
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_address_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILL
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] kill_addr_q;      // address of the abandoned read in KILL
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];
    logic [1:0]  count_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    logic        redirect;
    logic        accept;
    logic [31:0] target_aligned;

    assign redirect       = branch_flag_i & ~stall_i;
    assign target_aligned = {branch_address_i[31:2], 2'b00};

    // The request depends only on registered state, so it cannot change until
    // an ack arrives: without an ack nothing is pushed, so count_q never grows,
    // and a redirect moves the pending address into kill_addr_q.
    assign mem_req_o  = ((state_q == REQ) && (count_q != 2'd2)) || (state_q == KILL);
    assign mem_addr_o = (state_q == KILL) ? kill_addr_q : {fetch_pc_q[31:2], 2'b00};

    // A word is kept only for a live request in REQ with no redirect that cycle.
    assign accept = (state_q == REQ) && mem_req_o && mem_ack_i && !redirect;

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            pc_q       <= 32'h0000_0000;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
        end else begin
            // Control FSM
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (redirect && mem_req_o && !mem_ack_i) begin
                        state_q     <= KILL;
                        kill_addr_q <= mem_addr_o;
                    end
                end
                KILL: begin
                    if (mem_ack_i) state_q <= REQ;
                end
                default: state_q <= IDLE;
            endcase

            // Fetch address
            if (redirect) begin
                fetch_pc_q <= target_aligned;
            end else if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            // Output register and FIFO.
            // NOTE: the FIFO storage is not reset; count_q alone decides which
            // entries are meaningful, so stale contents are never observed.
            if (redirect) begin
                count_q <= 2'd0;
                pc_q    <= branch_address_i;
                inst_q  <= NOP_INST;
                valid_q <= 1'b0;
            end else if (!stall_i) begin
                if (count_q != 2'd0) begin
                    pc_q    <= fifo_pc_q[0];
                    inst_q  <= fifo_inst_q[0];
                    valid_q <= 1'b1;
                    if (count_q == 2'd1) begin
                        if (accept) begin
                            fifo_pc_q[0]   <= fetch_pc_q;
                            fifo_inst_q[0] <= mem_rdata_i;
                        end else begin
                            count_q <= 2'd0;
                        end
                    end else begin
                        fifo_pc_q[0]   <= fifo_pc_q[1];
                        fifo_inst_q[0] <= fifo_inst_q[1];
                        if (accept) begin
                            fifo_pc_q[1]   <= fetch_pc_q;
                            fifo_inst_q[1] <= mem_rdata_i;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end else if (accept) begin
                    // Bypass: empty FIFO, word goes straight to decode.
                    pc_q    <= fetch_pc_q;
                    inst_q  <= mem_rdata_i;
                    valid_q <= 1'b1;
                end else begin
                    inst_q  <= NOP_INST;
                    valid_q <= 1'b0;
                end
            end else if (accept) begin
                // Stalled: requests only issue with space, so count_q < 2 here.
                fifo_pc_q[count_q[0]]   <= fetch_pc_q;
                fifo_inst_q[count_q[0]] <= mem_rdata_i;
                count_q                 <= count_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- directed testbench for if_fetch
//
// Memory model: rdata is a fixed function of the address. ack is either tied
// to mem_req_o (single-cycle memory) or driven by hand for delayed acks.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_address_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    logic ack_auto;
    logic ack_manual;

    int n_chk;
    int n_pass;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    assign mem_ack_i   = ack_auto ? mem_req_o : ack_manual;
    assign mem_rdata_i = mem_word(mem_addr_o);

    if_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .branch_flag_i    (branch_flag_i),
        .branch_address_i (branch_address_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .inst_valid_o     (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // rst dominates stall, branch and ack on the same edge.
    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b1; branch_flag_i = 1'b1;
        branch_address_i = 32'h0000_5554; ack_manual = 1'b1; ack_auto = 1'b0;
        cyc(); cyc();
        n_chk++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); else n_pass++;
        n_chk++; if (inst_o !== NOP) $display("FAIL reset_inst: got %h want %h", inst_o, NOP); else n_pass++;
        n_chk++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req_o); else n_pass++;
    endtask

    // Single-cycle memory: addresses 0,4,8..., first valid two edges after rst.
    task automatic test_stream();
        rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; ack_manual = 1'b0; ack_auto = 1'b1;
        cyc();  // edge: IDLE -> REQ
        n_chk++; if (mem_req_o !== 1'b1) $display("FAIL stream_first_req: got %b want 1", mem_req_o); else n_pass++;
        n_chk++; if (mem_addr_o !== 32'h0) $display("FAIL stream_first_addr: got %h want 0", mem_addr_o); else n_pass++;
        n_chk++; if (inst_valid_o !== 1'b0) $display("FAIL stream_early_valid: got %b want 0", inst_valid_o); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_chk++; if (pc_o !== 32'(4*k)) $display("FAIL stream_pc[%0d]: got %h want %h", k, pc_o, 32'(4*k)); else n_pass++;
            n_chk++; if (inst_o !== mem_word(32'(4*k))) $display("FAIL stream_inst[%0d]: got %h want %h", k, inst_o, mem_word(32'(4*k))); else n_pass++;
            n_chk++; if (inst_valid_o !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", k, inst_valid_o); else n_pass++;
            n_chk++; if (mem_addr_o !== 32'(4*k+4)) $display("FAIL stream_addr[%0d]: got %h want %h", k, mem_addr_o, 32'(4*k+4)); else n_pass++;
        end
    endtask

    // Stall 5 cycles with pc_o=20 on the output: two words (24, 28) buffered.
    task automatic test_stall();
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_chk++; if (pc_o !== 32'd20 || inst_valid_o !== 1'b1)
                $display("FAIL stall_hold[%0d]: got pc %h v %b want pc 14 v 1", k, pc_o, inst_valid_o); else n_pass++;
            n_chk++; if (mem_req_o !== (k == 0))
                $display("FAIL stall_req[%0d]: got %b want %b", k, mem_req_o, (k == 0)); else n_pass++;
        end
        stall_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_chk++; if (pc_o !== 32'(24+4*k) || inst_o !== mem_word(32'(24+4*k)) || inst_valid_o !== 1'b1)
                $display("FAIL drain[%0d]: got pc %h inst %h v %b want pc %h", k, pc_o, inst_o, inst_valid_o, 32'(24+4*k)); else n_pass++;
        end
    endtask

    // Fill the FIFO, then redirect to 0x102.
    task automatic test_redirect_full();
        stall_i = 1'b1;
        cyc(); cyc(); cyc();
        n_chk++; if (mem_req_o !== 1'b0) $display("FAIL full_req: got %b want 0", mem_req_o); else n_pass++;
        n_chk++; if (pc_o !== 32'd36) $display("FAIL full_hold_pc: got %h want %h", pc_o, 32'd36); else n_pass++;
        stall_i = 1'b0; branch_flag_i = 1'b1; branch_address_i = 32'h0000_0102;
        cyc();
        branch_flag_i = 1'b0;
        n_chk++; if (pc_o !== 32'h102 || inst_o !== NOP || inst_valid_o !== 1'b0)
            $display("FAIL redir_bubble: got pc %h inst %h v %b want 102 %h 0", pc_o, inst_o, inst_valid_o, NOP); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100)
            $display("FAIL redir_addr: got req %b addr %h want 1 100", mem_req_o, mem_addr_o); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_chk++; if (pc_o !== 32'(32'h100+4*k) || inst_o !== mem_word(32'(32'h100+4*k)) || inst_valid_o !== 1'b1)
                $display("FAIL redir_stream[%0d]: got pc %h inst %h v %b want pc %h", k, pc_o, inst_o, inst_valid_o, 32'(32'h100+4*k)); else n_pass++;
        end
    endtask

    // Redirect with same-cycle ack, then a 3-cycle ack with redirect in the first wait cycle.
    task automatic test_kill();
        branch_flag_i = 1'b1; branch_address_i = 32'h0000_0200;
        cyc();
        branch_flag_i = 1'b0; ack_auto = 1'b0; ack_manual = 1'b0;
        n_chk++; if (pc_o !== 32'h200 || inst_valid_o !== 1'b0)
            $display("FAIL ackredir_out: got pc %h v %b want 200 0", pc_o, inst_valid_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200)
            $display("FAIL ackredir_addr: got req %b addr %h want 1 200", mem_req_o, mem_addr_o); else n_pass++;
        cyc();
        branch_flag_i = 1'b1; branch_address_i = 32'h0000_0300;
        n_chk++; if (mem_addr_o !== 32'h200) $display("FAIL kill_wait1_addr: got %h want 200", mem_addr_o); else n_pass++;
        cyc();
        branch_flag_i = 1'b0;
        n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200)
            $display("FAIL kill_hold_addr: got req %b addr %h want 1 200", mem_req_o, mem_addr_o); else n_pass++;
        n_chk++; if (pc_o !== 32'h300 || inst_o !== NOP || inst_valid_o !== 1'b0)
            $display("FAIL kill_bubble: got pc %h inst %h v %b want 300 %h 0", pc_o, inst_o, inst_valid_o, NOP); else n_pass++;
        cyc();
        ack_manual = 1'b1;
        n_chk++; if (mem_addr_o !== 32'h200) $display("FAIL kill_ack_addr: got %h want 200", mem_addr_o); else n_pass++;
        cyc();
        ack_manual = 1'b0;
        n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300)
            $display("FAIL kill_next_addr: got req %b addr %h want 1 300", mem_req_o, mem_addr_o); else n_pass++;
        n_chk++; if (inst_valid_o !== 1'b0 || inst_o !== NOP)
            $display("FAIL kill_dropped: got inst %h v %b want %h 0", inst_o, inst_valid_o, NOP); else n_pass++;
        ack_auto = 1'b1;
        cyc();
        n_chk++; if (pc_o !== 32'h300 || inst_o !== mem_word(32'h300) || inst_valid_o !== 1'b1)
            $display("FAIL kill_resume: got pc %h inst %h v %b want 300 %h 1", pc_o, inst_o, inst_valid_o, mem_word(32'h300)); else n_pass++;
    endtask

    // Branch while stalled is ignored.
    task automatic test_stall_branch();
        stall_i = 1'b1; branch_flag_i = 1'b1; branch_address_i = 32'h0000_0500;
        cyc();
        n_chk++; if (mem_addr_o !== 32'h308) $display("FAIL stbr_addr: got %h want 308", mem_addr_o); else n_pass++;
        n_chk++; if (pc_o !== 32'h300 || inst_valid_o !== 1'b1)
            $display("FAIL stbr_hold: got pc %h v %b want 300 1", pc_o, inst_valid_o); else n_pass++;
        cyc();
        stall_i = 1'b0; branch_flag_i = 1'b0;
        cyc();
        n_chk++; if (pc_o !== 32'h304 || inst_o !== mem_word(32'h304) || inst_valid_o !== 1'b1)
            $display("FAIL stbr_out: got pc %h inst %h v %b want 304", pc_o, inst_o, inst_valid_o); else n_pass++;
        n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h30c)
            $display("FAIL stbr_fetch: got req %b addr %h want 1 30c", mem_req_o, mem_addr_o); else n_pass++;
    endtask

    // Reset during a pending request; the late ack is ignored.
    task automatic test_reset_pending();
        ack_auto = 1'b0; ack_manual = 1'b0;
        n_chk++; if (mem_req_o !== 1'b1) $display("FAIL rp_pending: got %b want 1", mem_req_o); else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0; ack_manual = 1'b1;
        n_chk++; if (pc_o !== 32'h0 || inst_o !== NOP || inst_valid_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL rp_reset: got pc %h inst %h v %b req %b want 0 %h 0 0", pc_o, inst_o, inst_valid_o, mem_req_o, NOP); else n_pass++;
        cyc();
        ack_manual = 1'b0;
        n_chk++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0 || inst_valid_o !== 1'b0)
            $display("FAIL rp_restart: got req %b addr %h v %b want 1 0 0", mem_req_o, mem_addr_o, inst_valid_o); else n_pass++;
        ack_auto = 1'b1;
        cyc();
        n_chk++; if (pc_o !== 32'h0 || inst_o !== mem_word(32'h0) || inst_valid_o !== 1'b1 || mem_addr_o !== 32'h4)
            $display("FAIL rp_first: got pc %h inst %h v %b addr %h want 0 %h 1 4", pc_o, inst_o, inst_valid_o, mem_addr_o, mem_word(32'h0)); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_address_i = 32'h0;
        ack_auto = 1'b0; ack_manual = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_kill();
        test_stall_branch();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
